line_delay_buffer: RTL

Parametrised multi-line delay buffer for the Sobel datapath; it generalises the fixed 8-bit, 4-cell shift FIFO. It accepts one pixel per enabled clock and presents NUM_LINES taps, with tap k delayed by (k+1)·LINE_LEN accepted samples, as the row inputs of the 3×3 window. Storage is circular with a shared wrap-around pointer, not a shift chain. A fill counter masks taps that are not yet valid and flags when the window is primed.

---
 rtl/line_delay_buffer_pkg.sv | 20 ++
 rtl/line_delay_buffer_if.sv | 22 ++
 rtl/line_delay_buffer_cell.sv | 38 +++
 rtl/line_delay_buffer.sv | 73 +++++++
 4 files changed

// File: rtl/line_delay_buffer_pkg.sv
// Shared Sobel datapath constants and helpers: default pixel width, pointer/counter
// widths and the tap slice position inside the packed output bus.
package line_delay_buffer_pkg;

    localparam int PIX_W_DEF = 8;

    function automatic int ptr_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Counter must reach lines*len+1, so size for lines*len+2 states.
    function automatic int cnt_width(input int lines, input int len);
        return $clog2(lines * len + 2);
    endfunction

    function automatic int tap_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/line_delay_buffer_if.sv
// Pixel stream in, delayed row taps out. The pixel source drives through master,
// the buffer receives through slave.
interface line_delay_buffer_if
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W_DEF,
    parameter int LINE_LEN   = 4,
    parameter int NUM_LINES  = 2
);
    localparam int PTR_W = ptr_width(LINE_LEN);

    logic                            Enable;
    logic                            Clear;
    logic [DATA_WIDTH-1:0]           DataIn;
    logic [NUM_LINES*DATA_WIDTH-1:0] DataOut;
    logic                            Primed;
    logic [PTR_W-1:0]                ColIdx;

    modport master (output Enable, Clear, DataIn, input DataOut, Primed, ColIdx);
    modport slave  (input Enable, Clear, DataIn, output DataOut, Primed, ColIdx);

endinterface

// File: rtl/line_delay_buffer_cell.sv
// One circular line of LINE_LEN words plus its registered tap. The old word at the
// shared pointer feeds both the tap and the next line in the chain.
module line_delay_cell #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PTR_W-1:0]      i_ptr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_old,
    output logic [DATA_WIDTH-1:0] o_tap
);
    logic [DATA_WIDTH-1:0] r_mem [LINE_LEN];
    logic [DATA_WIDTH-1:0] r_tap;

    assign o_old = r_mem[i_ptr];
    assign o_tap = r_tap;

    // Storage is never reset; the fill mask upstream hides stale words.
    always_ff @(posedge CLK) begin
        if (i_en && !i_clr)
            r_mem[i_ptr] <= i_din;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_tap <= '0;
        else if (i_clr)
            r_tap <= '0;
        else if (i_en)
            r_tap <= r_mem[i_ptr];
    end

endmodule

// File: rtl/line_delay_buffer.sv
// Multi-line delay buffer: NUM_LINES chained circular lines sharing one write pointer,
// with a saturating fill counter that masks taps until their data is genuine.
module line_delay_buffer
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W_DEF,
    parameter int LINE_LEN   = 4,
    parameter int NUM_LINES  = 2
) (
    input  logic               CLK,
    input  logic               RSTn,
    line_delay_buffer_if.slave bus
);
    localparam int               PTR_W   = ptr_width(LINE_LEN);
    localparam int               CNT_W   = cnt_width(NUM_LINES, LINE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LINES * LINE_LEN + 1);
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(LINE_LEN - 1);

    logic [PTR_W-1:0]                         r_ptr;
    logic [CNT_W-1:0]                         r_cnt;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0]     w_din;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0]     w_old;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0]     w_tap;
    logic                                     w_unused_last;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (bus.Clear) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (bus.Enable) begin
            r_ptr <= (r_ptr == PTR_END) ? '0 : r_ptr + 1'b1;
            if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign w_din[k] = bus.DataIn;
        end else begin : g_link
            assign w_din[k] = w_old[k-1];
        end

        line_delay_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .LINE_LEN   (LINE_LEN),
            .PTR_W      (PTR_W)
        ) u_cell (
            .CLK   (CLK),
            .RSTn  (RSTn),
            .i_en  (bus.Enable),
            .i_clr (bus.Clear),
            .i_ptr (r_ptr),
            .i_din (w_din[k]),
            .o_old (w_old[k]),
            .o_tap (w_tap[k])
        );

        // Tap k only carries a real sample once more than (k+1) lines have been accepted.
        assign bus.DataOut[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
            (r_cnt > CNT_W'((k + 1) * LINE_LEN)) ? w_tap[k] : '0;
    end

    // The last line's outgoing word has no consumer.
    assign w_unused_last = ^w_old[NUM_LINES-1];

    assign bus.Primed = (r_cnt == CNT_MAX);
    assign bus.ColIdx = r_ptr;

endmodule
